// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform block.
// Contents:
//   - state encodings of the frame FSM
//   - mode encodings (chessboard / city-block)
//   - neighbour-offset codes and the per-slot offset lookup
//   - addr_w(): number of address bits needed for a given depth
package dt_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FW_FETCH = 4'd1;
  localparam logic [3:0] ST_FW_NB    = 4'd2;
  localparam logic [3:0] ST_FW_WR    = 4'd3;
  localparam logic [3:0] ST_FW_END   = 4'd4;
  localparam logic [3:0] ST_BW_SELF  = 4'd5;
  localparam logic [3:0] ST_BW_NB    = 4'd6;
  localparam logic [3:0] ST_BW_WR    = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  localparam logic MODE_CHESS = 1'b0;
  localparam logic MODE_CITY  = 1'b1;

  // Last neighbour slot index per mode (4 or 2 neighbours).
  localparam logic [1:0] LAST_SLOT_CHESS = 2'd3;
  localparam logic [1:0] LAST_SLOT_CITY  = 2'd1;

  // Per-axis offset codes: 0, +1, -1.
  localparam logic [1:0] OFS_ZERO = 2'b00;
  localparam logic [1:0] OFS_POS  = 2'b01;
  localparam logic [1:0] OFS_NEG  = 2'b11;

  typedef struct packed {
    logic [1:0] dr;
    logic [1:0] dc;
  } nb_ofs_t;

  // Neighbour offset for a given pass, mode and slot.
  // Forward chessboard: NW, N, NE, W.  Forward city-block: N, W.
  // Backward chessboard: E, SW, S, SE. Backward city-block: E, S.
  function automatic nb_ofs_t nb_ofs(input logic bw, input logic md, input logic [1:0] slot);
    nb_ofs_t o;
    o = '{OFS_ZERO, OFS_ZERO};
    case ({bw, md, slot})
      4'b0000: o = '{OFS_NEG,  OFS_NEG};
      4'b0001: o = '{OFS_NEG,  OFS_ZERO};
      4'b0010: o = '{OFS_NEG,  OFS_POS};
      4'b0011: o = '{OFS_ZERO, OFS_NEG};
      4'b0100: o = '{OFS_NEG,  OFS_ZERO};
      4'b0101: o = '{OFS_ZERO, OFS_NEG};
      4'b1000: o = '{OFS_ZERO, OFS_POS};
      4'b1001: o = '{OFS_POS,  OFS_NEG};
      4'b1010: o = '{OFS_POS,  OFS_ZERO};
      4'b1011: o = '{OFS_POS,  OFS_POS};
      4'b1100: o = '{OFS_ZERO, OFS_POS};
      4'b1101: o = '{OFS_POS,  OFS_ZERO};
      default: o = '{OFS_ZERO, OFS_ZERO};
    endcase
    return o;
  endfunction

  function automatic int addr_w(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/dt_min_sat.sv
// Combinational minimum of four distance values with a per-input valid
// mask, followed by a saturating increment.
// Ports:
//   vals    - four DIST_W values packed, slot 0 in the low bits
//   valid   - one bit per slot; masked slots never win the minimum
//   min_inc - min(valid vals) + 1, clamped at 2^DIST_W-1
module dt_min_sat
  import dt_pkg::*;
#(
  parameter int DIST_W = 8
) (
  input  logic [4*DIST_W-1:0] vals,
  input  logic [3:0]          valid,
  output logic [DIST_W-1:0]   min_inc
);

  localparam logic [DIST_W-1:0] MAX_V = '1;

  logic [DIST_W-1:0] masked [4];
  logic [DIST_W-1:0] min_a;
  logic [DIST_W-1:0] min_b;
  logic [DIST_W-1:0] min_val;

  // A masked slot becomes the maximum value so it cannot be selected.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign masked[gi] = valid[gi] ? vals[gi*DIST_W +: DIST_W] : MAX_V;
    end
  endgenerate

  assign min_a   = (masked[0] < masked[1]) ? masked[0] : masked[1];
  assign min_b   = (masked[2] < masked[3]) ? masked[2] : masked[3];
  assign min_val = (min_a < min_b) ? min_a : min_b;
  assign min_inc = (min_val == MAX_V) ? MAX_V : min_val + DIST_W'(1);

endmodule

// File: rtl/dt_param.sv
// Two-pass distance transform over a binary image held in an external ROM,
// writing distances into an external result RAM.
// Ports:
//   clk, reset (async, active low), start, mode (0 chessboard, 1 city-block)
//   busy, fwpass_finish (pulse), done (held)
//   sti_rd/sti_addr/sti_di           - stimulus ROM, one word per STI_W pixels
//   res_rd/res_wr/res_addr/res_do/res_di - result RAM, one pixel per address
// All strobes and addresses are registered. Read data is sampled on the
// posedge that ends the cycle in which the strobe was high.
module dt_param
  import dt_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int STI_W  = 16,
  parameter int DIST_W = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   mode,
  output logic                                   busy,
  output logic                                   fwpass_finish,
  output logic                                   done,
  output logic                                   sti_rd,
  output logic [addr_w(IMG_W*IMG_H/STI_W)-1:0]   sti_addr,
  input  logic [STI_W-1:0]                       sti_di,
  output logic                                   res_rd,
  output logic                                   res_wr,
  output logic [addr_w(IMG_W*IMG_H)-1:0]         res_addr,
  output logic [DIST_W-1:0]                      res_do,
  input  logic [DIST_W-1:0]                      res_di
);

  localparam int ADDR_W = addr_w(IMG_W*IMG_H);
  localparam int STI_AW = addr_w(IMG_W*IMG_H/STI_W);
  localparam int CW     = addr_w(IMG_W);
  localparam int SW     = addr_w(STI_W);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W*IMG_H-1);

  logic [3:0]        state_reg, state_next;
  logic [ADDR_W-1:0] pix_reg, pix_next;
  logic [1:0]        slot_reg, slot_next;
  logic              mode_reg, mode_next;
  logic [STI_W-1:0]  word_reg, word_next;
  logic [DIST_W-1:0] self_reg, self_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              fw_fin_reg, fw_fin_next;
  logic              sti_rd_reg, sti_rd_next;
  logic [STI_AW-1:0] sti_addr_reg, sti_addr_next;
  logic              res_rd_reg, res_rd_next;
  logic              res_wr_reg, res_wr_next;
  logic [ADDR_W-1:0] res_addr_reg, res_addr_next;
  logic [DIST_W-1:0] res_do_reg, res_do_next;
  logic [DIST_W-1:0] vals_reg  [4];
  logic [DIST_W-1:0] vals_next [4];
  logic [DIST_W-1:0] vals_now  [4];
  logic [4*DIST_W-1:0] vals_flat;

  // Position of the current pixel relative to the image border.
  logic [CW-1:0] col;
  logic at_left, at_right, at_top, at_bot;
  assign col      = pix_reg[CW-1:0];
  assign at_left  = (col == '0);
  assign at_right = (col == CW'(IMG_W-1));
  assign at_top   = (pix_reg < ADDR_W'(IMG_W));
  assign at_bot   = (pix_reg >= ADDR_W'(IMG_W*(IMG_H-1)));

  logic [1:0] last_slot;
  logic [3:0] valid_mask;
  assign last_slot  = (mode_reg == MODE_CITY) ? LAST_SLOT_CITY : LAST_SLOT_CHESS;
  assign valid_mask = (mode_reg == MODE_CITY) ? 4'b0011 : 4'b1111;

  // A neighbour read is in flight when res_rd was issued from an NB state;
  // its data lands in the slot that was being issued.
  logic nb_cap;
  assign nb_cap = res_rd_reg && ((state_reg == ST_FW_NB) || (state_reg == ST_BW_NB));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_vals
      assign vals_now[gi] = (nb_cap && (slot_reg == 2'(gi))) ? res_di : vals_reg[gi];
      assign vals_flat[gi*DIST_W +: DIST_W] = vals_now[gi];
    end
  endgenerate

  logic [DIST_W-1:0] min_inc;
  logic [DIST_W-1:0] bw_val;

  dt_min_sat #(.DIST_W(DIST_W)) u_min_sat (
    .vals    (vals_flat),
    .valid   (valid_mask),
    .min_inc (min_inc)
  );

  assign bw_val = (self_reg < min_inc) ? self_reg : min_inc;

  // Next neighbour read to issue: slot 0 on entry to an NB state, else the
  // slot after the one just issued.
  logic       bw_pass;
  logic [1:0] issue_slot;
  nb_ofs_t    ofs;
  logic [ADDR_W-1:0] row_off, col_off, issue_addr;
  logic       issue_oob;

  assign bw_pass    = (state_reg == ST_BW_SELF) || (state_reg == ST_BW_NB);
  assign issue_slot = ((state_reg == ST_FW_NB) || (state_reg == ST_BW_NB)) ?
                      (slot_reg + 2'd1) : 2'd0;
  assign ofs        = nb_ofs(bw_pass, mode_reg, issue_slot);
  assign row_off    = (ofs.dr == OFS_NEG) ? (ADDR_W'(0) - ADDR_W'(IMG_W)) :
                      (ofs.dr == OFS_POS) ? ADDR_W'(IMG_W) : '0;
  assign col_off    = (ofs.dc == OFS_NEG) ? '1 :
                      (ofs.dc == OFS_POS) ? ADDR_W'(1) : '0;
  assign issue_addr = pix_reg + row_off + col_off;
  assign issue_oob  = ((ofs.dr == OFS_NEG) && at_top)  ||
                      ((ofs.dr == OFS_POS) && at_bot)  ||
                      ((ofs.dc == OFS_NEG) && at_left) ||
                      ((ofs.dc == OFS_POS) && at_right);

  // Pixel bit of the current pixel: on a word boundary the fresh ROM word is
  // used directly, otherwise the latched word. MSB is the leftmost pixel.
  logic [STI_W-1:0]  word_src, word_shift;
  logic              cur_bit;
  logic [ADDR_W-1:0] pix_inc, pix_dec;
  assign word_src   = sti_rd_reg ? sti_di : word_reg;
  assign word_shift = word_src << pix_reg[SW-1:0];
  assign cur_bit    = word_shift[STI_W-1];
  assign pix_inc    = pix_reg + ADDR_W'(1);
  assign pix_dec    = pix_reg - ADDR_W'(1);

  logic do_issue;
  logic next_bw;

  always_comb begin
    state_next    = state_reg;
    pix_next      = pix_reg;
    slot_next     = slot_reg;
    mode_next     = mode_reg;
    word_next     = word_reg;
    self_next     = self_reg;
    busy_next     = busy_reg;
    done_next     = done_reg;
    fw_fin_next   = 1'b0;
    sti_rd_next   = 1'b0;
    sti_addr_next = sti_addr_reg;
    res_rd_next   = 1'b0;
    res_wr_next   = 1'b0;
    res_addr_next = res_addr_reg;
    res_do_next   = res_do_reg;
    for (int i = 0; i < 4; i++) vals_next[i] = vals_now[i];
    do_issue = 1'b0;
    next_bw  = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next    = ST_FW_FETCH;
          busy_next     = 1'b1;
          done_next     = 1'b0;
          mode_next     = mode;
          pix_next      = '0;
          sti_rd_next   = 1'b1;
          sti_addr_next = '0;
        end
      end
      ST_FW_FETCH: begin
        word_next = word_src;
        if (cur_bit) begin
          state_next = ST_FW_NB;
          slot_next  = 2'd0;
          do_issue   = 1'b1;
        end else begin
          state_next    = ST_FW_WR;
          res_wr_next   = 1'b1;
          res_addr_next = pix_reg;
          res_do_next   = '0;
        end
      end
      ST_FW_NB: begin
        if (slot_reg == last_slot) begin
          state_next    = ST_FW_WR;
          res_wr_next   = 1'b1;
          res_addr_next = pix_reg;
          res_do_next   = min_inc;
        end else begin
          slot_next = issue_slot;
          do_issue  = 1'b1;
        end
      end
      ST_FW_WR: begin
        if (pix_reg == LAST_PIX) begin
          state_next  = ST_FW_END;
          fw_fin_next = 1'b1;
        end else begin
          state_next    = ST_FW_FETCH;
          pix_next      = pix_inc;
          sti_rd_next   = (pix_inc[SW-1:0] == '0);
          sti_addr_next = pix_inc[ADDR_W-1:SW];
        end
      end
      ST_FW_END: begin
        state_next    = ST_BW_SELF;
        pix_next      = LAST_PIX;
        res_rd_next   = 1'b1;
        res_addr_next = LAST_PIX;
      end
      ST_BW_SELF: begin
        self_next = res_di;
        if (res_di == '0) begin
          next_bw = 1'b1;
        end else begin
          state_next = ST_BW_NB;
          slot_next  = 2'd0;
          do_issue   = 1'b1;
        end
      end
      ST_BW_NB: begin
        if (slot_reg == last_slot) begin
          state_next    = ST_BW_WR;
          res_wr_next   = 1'b1;
          res_addr_next = pix_reg;
          res_do_next   = bw_val;
        end else begin
          slot_next = issue_slot;
          do_issue  = 1'b1;
        end
      end
      ST_BW_WR: begin
        next_bw = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase

    // Advance the backward pass, or finish after pixel 0.
    if (next_bw) begin
      if (pix_reg == '0) begin
        state_next = ST_DONE;
        done_next  = 1'b1;
        busy_next  = 1'b0;
      end else begin
        state_next    = ST_BW_SELF;
        pix_next      = pix_dec;
        res_rd_next   = 1'b1;
        res_addr_next = pix_dec;
      end
    end

    // Out-of-image neighbours cost a cycle but no read; they count as 0.
    if (do_issue) begin
      if (issue_oob) begin
        vals_next[issue_slot] = '0;
      end else begin
        res_rd_next   = 1'b1;
        res_addr_next = issue_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      pix_reg      <= '0;
      slot_reg     <= '0;
      mode_reg     <= MODE_CHESS;
      word_reg     <= '0;
      self_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      fw_fin_reg   <= 1'b0;
      sti_rd_reg   <= 1'b0;
      sti_addr_reg <= '0;
      res_rd_reg   <= 1'b0;
      res_wr_reg   <= 1'b0;
      res_addr_reg <= '0;
      res_do_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pix_reg      <= pix_next;
      slot_reg     <= slot_next;
      mode_reg     <= mode_next;
      word_reg     <= word_next;
      self_reg     <= self_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      fw_fin_reg   <= fw_fin_next;
      sti_rd_reg   <= sti_rd_next;
      sti_addr_reg <= sti_addr_next;
      res_rd_reg   <= res_rd_next;
      res_wr_reg   <= res_wr_next;
      res_addr_reg <= res_addr_next;
      res_do_reg   <= res_do_next;
    end
  end

  generate
    for (gi = 0; gi < 4; gi++) begin : g_vals_ff
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) vals_reg[gi] <= '0;
        else        vals_reg[gi] <= vals_next[gi];
      end
    end
  endgenerate

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign fwpass_finish = fw_fin_reg;
  assign sti_rd        = sti_rd_reg;
  assign sti_addr      = sti_addr_reg;
  assign res_rd        = res_rd_reg;
  assign res_wr        = res_wr_reg;
  assign res_addr      = res_addr_reg;
  assign res_do        = res_do_reg;

endmodule

// File: tb/tb_dt_param.sv
// Directed bench for dt_param on a 16x16 image, 8-pixel ROM words and
// 3-bit distances (so large objects exercise the saturation at 7).
// ROM and RAM models return read data in the cycle of the strobe; results
// are compared with a brute-force nearest-background distance.
module tb_dt_param;

  localparam int W      = 16;
  localparam int H      = 16;
  localparam int N      = W * H;
  localparam int SW     = 8;
  localparam int DW     = 3;
  localparam int MAXV   = 7;
  localparam int BUDGET = 4000;

  logic          clk;
  logic          reset;
  logic          start;
  logic          mode;
  logic          busy;
  logic          fwpass_finish;
  logic          done;
  logic          sti_rd;
  logic [4:0]    sti_addr;
  logic [SW-1:0] sti_di;
  logic          res_rd;
  logic          res_wr;
  logic [7:0]    res_addr;
  logic [DW-1:0] res_do;
  logic [DW-1:0] res_di;

  logic          img [N];
  logic [SW-1:0] rom [N/SW];
  logic [DW-1:0] ram [N];

  int n_checks;
  int n_errors;

  dt_param #(.IMG_W(W), .IMG_H(H), .STI_W(SW), .DIST_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .mode          (mode),
    .busy          (busy),
    .fwpass_finish (fwpass_finish),
    .done          (done),
    .sti_rd        (sti_rd),
    .sti_addr      (sti_addr),
    .sti_di        (sti_di),
    .res_rd        (res_rd),
    .res_wr        (res_wr),
    .res_addr      (res_addr),
    .res_do        (res_do),
    .res_di        (res_di)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sti_rd) sti_di <= rom[sti_addr];
    if (res_rd) res_di <= ram[res_addr];
  end

  always @(posedge clk) begin
    if (res_wr) ram[res_addr] <= res_do;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int p = 0; p < N; p++) img[p] = 1'b0;
  endtask

  task automatic set_rect(input int r0, input int r1, input int c0, input int c1, input logic v);
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) img[r*W+c] = v;
  endtask

  task automatic load_rom();
    for (int a = 0; a < N/SW; a++)
      for (int k = 0; k < SW; k++) rom[a][SW-1-k] = img[a*SW+k];
  endtask

  // Distance to the nearest background pixel; everything outside the image
  // is background. Clamped at the largest representable value.
  function automatic int model_px(input int p, input int m);
    int r, c, d, dd, dr, dc;
    r = p / W;
    c = p % W;
    if (!img[p]) return 0;
    d = r + 1;
    if (H - r < d) d = H - r;
    if (c + 1 < d) d = c + 1;
    if (W - c < d) d = W - c;
    for (int q = 0; q < N; q++) begin
      if (!img[q]) begin
        dr = q / W - r; if (dr < 0) dr = -dr;
        dc = q % W - c; if (dc < 0) dc = -dc;
        dd = (m != 0) ? dr + dc : ((dr > dc) ? dr : dc);
        if (dd < d) d = dd;
      end
    end
    if (d > MAXV) d = MAXV;
    return d;
  endfunction

  task automatic compare_image(input string tag, input int m);
    int bad;
    bad = 0;
    for (int p = 0; p < N; p++)
      if (int'(ram[p]) != model_px(p, m)) bad++;
    chk(tag, bad, 0);
  endtask

  // Runs one frame; optionally pokes start with the other mode mid-frame.
  task automatic run_frame(input string name, input int m, input bit poke);
    int  cyc, fw_cnt, both_rw, fw_done, bound;
    bit  seen;
    bound = 2 * N * (((m != 0) ? 2 : 4) + 2) + 2 * N / SW + 8;
    load_rom();
    @(negedge clk);
    mode  = m[0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, int'(busy), 1);
    chk({name, "_done_clr"}, int'(done), 0);
    cyc = 1; fw_cnt = 0; both_rw = 0; fw_done = 0; seen = 1'b0;
    while (!seen && cyc < BUDGET) begin
      if (poke && cyc == 40) begin start = 1'b1; mode = ~mode; end
      if (poke && cyc == 41) start = 1'b0;
      @(negedge clk);
      cyc++;
      if (fwpass_finish) fw_cnt++;
      if (res_rd && res_wr) both_rw++;
      if (fwpass_finish && done) fw_done++;
      if (done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    chk({name, "_fw_pulse"}, fw_cnt, 1);
    chk({name, "_rd_wr_excl"}, both_rw, 0);
    chk({name, "_fw_done_excl"}, fw_done, 0);
    chk({name, "_latency_ok"}, (cyc <= bound) ? 1 : 0, 1);
    chk({name, "_busy_low"}, int'(busy), 0);
    $display("frame %s mode %0d cycles %0d bound %0d", name, m, cyc, bound);
  endtask

  initial begin
    int zc, cyc;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    clear_img();
    load_rom();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fw", int'(fwpass_finish), 0);
    chk("rst_sti_rd", int'(sti_rd), 0);
    chk("rst_res_rd", int'(res_rd), 0);
    chk("rst_res_wr", int'(res_wr), 0);
    chk("rst_sti_addr", int'(sti_addr), 0);
    chk("rst_res_addr", int'(res_addr), 0);
    chk("rst_res_do", int'(res_do), 0);
    reset = 1'b1;
    @(negedge clk);

    // Single object pixel at (8,8).
    clear_img();
    img[8*W+8] = 1'b1;
    run_frame("dot_chess", 0, 1'b0);
    chk("dot_chess_px", int'(ram[136]), 1);
    compare_image("dot_chess_img", 0);
    repeat (3) @(negedge clk);
    chk("dot_done_held", int'(done), 1);
    run_frame("dot_city", 1, 1'b0);
    chk("dot_city_px", int'(ram[136]), 1);
    compare_image("dot_city_img", 1);

    // 3x3 block at rows/cols 5..7 with (5,5) cleared.
    clear_img();
    set_rect(5, 7, 5, 7, 1'b1);
    img[5*W+5] = 1'b0;
    run_frame("blk_chess", 0, 1'b0);
    chk("blk_chess_ctr", int'(ram[102]), 1);
    chk("blk_chess_edge", int'(ram[119]), 1);
    compare_image("blk_chess_img", 0);
    run_frame("blk_city", 1, 1'b0);
    chk("blk_city_ctr", int'(ram[102]), 2);
    compare_image("blk_city_img", 1);

    // Whole image is object: interior distance 8 must clamp at 7.
    clear_img();
    set_rect(0, H-1, 0, W-1, 1'b1);
    run_frame("full_chess", 0, 1'b0);
    chk("full_ctr_clamp", int'(ram[119]), 7);
    chk("full_corner", int'(ram[0]), 1);
    zc = 0;
    for (int p = 0; p < N; p++) if (ram[p] == '0) zc++;
    chk("full_no_wrap", zc, 0);
    compare_image("full_chess_img", 0);

    // Rectangle with holes; second run has start/mode poked while busy.
    clear_img();
    set_rect(2, 13, 1, 14, 1'b1);
    img[7*W+9] = 1'b0;
    img[3*W+3] = 1'b0;
    run_frame("holes_chess", 0, 1'b0);
    compare_image("holes_chess_img", 0);
    run_frame("holes_city", 1, 1'b1);
    compare_image("holes_city_img", 1);

    // Object touching the top border.
    clear_img();
    set_rect(0, 3, 0, W-1, 1'b1);
    run_frame("border_city", 1, 1'b0);
    chk("border_left", int'(ram[0]), 1);
    chk("border_right", int'(ram[15]), 1);
    chk("border_r1c5", int'(ram[21]), 2);
    compare_image("border_city_img", 1);

    // Abort during the forward pass at pixel 100, then reprocess.
    clear_img();
    set_rect(1, 14, 2, 12, 1'b1);
    img[9*W+6] = 1'b0;
    load_rom();
    @(negedge clk);
    mode  = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(res_wr && res_addr == 8'd100) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached", (res_wr && res_addr == 8'd100) ? 1 : 0, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_res_wr", int'(res_wr), 0);
    chk("abort_res_rd", int'(res_rd), 0);
    chk("abort_sti_rd", int'(sti_rd), 0);
    chk("abort_res_addr", int'(res_addr), 0);
    chk("abort_res_do", int'(res_do), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame("rerun_chess", 0, 1'b0);
    compare_image("rerun_chess_img", 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dt_param.md
DT_PARAM -- requirements
Module: dt_param

Interface
REQ-001 Parameter IMG_W, default 128: image width in pixels; power of 2, 16..1024.
REQ-002 Parameter IMG_H, default 128: image height in pixels; power of 2, 2..1024.
REQ-003 Parameter STI_W, default 16: pixels per stimulus ROM word; power of 2, divides IMG_W.
REQ-004 Parameter DIST_W, default 8: distance value width in bits.
REQ-005 Port clk, input, 1: the single clock; all state updates on posedge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port start, input, 1: one-cycle request to process a frame; honoured only in IDLE or DONE.
REQ-008 Port mode, input, 1: 0 = chessboard (8-neighbour), 1 = city-block (4-neighbour); sampled when start is accepted.
REQ-009 Port busy, output, 1: high from the cycle after start acceptance until done rises.
REQ-010 Port fwpass_finish, output, 1: one-cycle pulse after the last forward-pass write.
REQ-011 Port done, output, 1: high after the last backward-pass write; held until the next accepted start or reset.
REQ-012 Port sti_rd / sti_addr, output, 1 / log2(IMG_W*IMG_H/STI_W): ROM read strobe and word address.
REQ-013 Port sti_di, input, STI_W: ROM word; MSB is the leftmost pixel; valid at the posedge after the sti_rd cycle.
REQ-014 Port res_rd / res_wr / res_addr, output, 1 / 1 / log2(IMG_W*IMG_H): result RAM strobes and pixel address (row*IMG_W + col).
REQ-015 Port res_do, output, DIST_W: write data; RAM writes it on the posedge where res_wr is high.
REQ-016 Port res_di, input, DIST_W: read data; valid at the posedge after the res_rd cycle.

Function
REQ-017 FSM states: IDLE, FW_FETCH, FW_NB, FW_WR, FW_END, BW_SELF, BW_NB, BW_WR, DONE.
REQ-018 Transitions: IDLE -> FW_FETCH on start. DONE -> FW_FETCH on start. FW_END -> BW_SELF. After the last backward pixel -> DONE.
REQ-019 Forward pass visits pixels 0..N-1 in raster order; N = IMG_W*IMG_H.
REQ-020 FW_FETCH issues one sti_rd per STI_W pixels and latches the word.
REQ-021 Forward, background pixel (bit 0): write 0 directly; no neighbour reads.
REQ-022 Forward, object pixel: read neighbours NW, N, NE, W (chessboard) or N, W (city-block); write min+1.
REQ-023 Backward pass visits pixels N-1..0.
REQ-024 Backward: read self. If 0, skip the pixel. Otherwise read E, SW, S, SE (chessboard) or E, S (city-block); write min(self, min+1).
REQ-025 Neighbours outside the image read as 0 without issuing res_rd.
REQ-026 The +1 saturates at 2^DIST_W-1; no wrap-around.
REQ-027 Reads may be pipelined: one res_rd per cycle, each result sampled on the following posedge.
REQ-028 res_rd and res_wr are never high in the same cycle.
REQ-029 Total latency from start to done is at most 2*N*(NB+2) + 2*N/STI_W + 8 cycles, where NB is the neighbour count (4 or 2).
REQ-030 start while busy is ignored; mode changes while busy are ignored.
REQ-031 fwpass_finish and done are never high in the same cycle.

Reset
REQ-032 While reset is low: FSM = IDLE; busy, done, fwpass_finish, sti_rd, res_rd, res_wr = 0; all addresses and res_do = 0.
REQ-033 Reset mid-frame aborts immediately; RAM contents are left as-is; the next start reprocesses the full frame.

Structure
REQ-034 Shared package dt_pkg holds: the state enum, mode encodings, neighbour-offset constants, and the address-width function.
REQ-035 One sub-module, dt_min_sat: combinational min of up to 4 DIST_W values, per-input valid mask, saturating +1.
REQ-036 The block contains no image-sized storage beyond one latched ROM word.

Verification
REQ-037 128x128, single object pixel at (64,64), both modes -> res[8256] = 1; all other pixels 0; done high.
REQ-038 3x3 object block at rows/cols 10..12 with (10,10) cleared -> res[1419] = 1 in chessboard mode, 2 in city-block mode.
REQ-039 Golden 128x128 Geometry and ICC17 stimuli, mode 0 -> 0 mismatches over 16384 pixels against the backward-pass golden; fwpass_finish pulses exactly once before done.
REQ-040 DIST_W = 3, 20x20 object block -> interior values clamp at 7; no value wraps to 0.
REQ-041 Reset pulled low during the forward pass at pixel 5000 -> all outputs 0 within the reset; after start, the result matches golden.
REQ-042 IMG_W = 64, IMG_H = 32, STI_W = 16 -> widths are 7-bit sti_addr and 11-bit res_addr; a border-touching object gives edge pixels = 1.
